// File: rtl/wave_oscillator.sv
// +----------------------------------------------------------------------------+
// | wave_oscillator: phase-accumulator oscillator producing sine, triangle,    |
// | saw and square samples through a two-stage pipeline.                       |
// | Optional hard-sync output sync_out when WAVE_OSC_SYNC_EN is defined.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wave_oscillator #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic [1:0]         mode,
  input  logic               phase_reset,
  output logic [OUT_W-1:0]   sample,
`ifdef WAVE_OSC_SYNC_EN
  output logic               sync_out,
`endif
  output logic               sample_valid
);

  // Only the top phase bits feed any waveform; keep just those in stage 1.
  localparam int c_p_bits = (OUT_W + 1 > 8) ? OUT_W + 1 : 8;

  localparam logic [1:0] c_mode_sine   = 2'd0;
  localparam logic [1:0] c_mode_tri    = 2'd1;
  localparam logic [1:0] c_mode_saw    = 2'd2;
  localparam logic [1:0] c_mode_square = 2'd3;

  logic [PHASE_W-1:0]  r_acc;
  logic [c_p_bits-1:0] r_p;
  logic [1:0]          r_mode;
  logic                r_v1;

  logic                w_accept;
  logic [PHASE_W-1:0]  w_base;
  logic [PHASE_W-1:0]  w_next_acc;
  logic [7:0]          w_k;
  logic [7:0]          w_kf;
  logic [10:0]         w_sine11;
  logic [OUT_W-1:0]    w_sine;
  logic [OUT_W-1:0]    w_tri_x;
  logic                w_msb;
  logic [OUT_W-1:0]    w_wave;

  // T[j] = round-half-up(1023.5*(1-cos(pi*j/128))), j = 0..64
  function automatic logic [10:0] quarter_sine(input logic [6:0] j);
    logic [10:0] t;
    t = 11'd0;
    case (j)
      7'd0:  t = 11'd0;    7'd1:  t = 11'd0;    7'd2:  t = 11'd1;    7'd3:  t = 11'd3;
      7'd4:  t = 11'd5;    7'd5:  t = 11'd8;    7'd6:  t = 11'd11;   7'd7:  t = 11'd15;
      7'd8:  t = 11'd20;   7'd9:  t = 11'd25;   7'd10: t = 11'd31;   7'd11: t = 11'd37;
      7'd12: t = 11'd44;   7'd13: t = 11'd52;   7'd14: t = 11'd60;   7'd15: t = 11'd69;
      7'd16: t = 11'd78;   7'd17: t = 11'd88;   7'd18: t = 11'd98;   7'd19: t = 11'd109;
      7'd20: t = 11'd121;  7'd21: t = 11'd133;  7'd22: t = 11'd146;  7'd23: t = 11'd159;
      7'd24: t = 11'd172;  7'd25: t = 11'd187;  7'd26: t = 11'd201;  7'd27: t = 11'd217;
      7'd28: t = 11'd232;  7'd29: t = 11'd248;  7'd30: t = 11'd265;  7'd31: t = 11'd282;
      7'd32: t = 11'd300;  7'd33: t = 11'd318;  7'd34: t = 11'd336;  7'd35: t = 11'd355;
      7'd36: t = 11'd374;  7'd37: t = 11'd394;  7'd38: t = 11'd414;  7'd39: t = 11'd434;
      7'd40: t = 11'd455;  7'd41: t = 11'd476;  7'd42: t = 11'd497;  7'd43: t = 11'd519;
      7'd44: t = 11'd541;  7'd45: t = 11'd563;  7'd46: t = 11'd586;  7'd47: t = 11'd609;
      7'd48: t = 11'd632;  7'd49: t = 11'd655;  7'd50: t = 11'd679;  7'd51: t = 11'd702;
      7'd52: t = 11'd726;  7'd53: t = 11'd751;  7'd54: t = 11'd775;  7'd55: t = 11'd799;
      7'd56: t = 11'd824;  7'd57: t = 11'd849;  7'd58: t = 11'd873;  7'd59: t = 11'd898;
      7'd60: t = 11'd923;  7'd61: t = 11'd948;  7'd62: t = 11'd973;  7'd63: t = 11'd998;
      7'd64: t = 11'd1024;
      default: t = 11'd0;
    endcase
    return t;
  endfunction

  assign w_accept   = en & sample_tick;
  assign w_base     = phase_reset ? '0 : r_acc;
  assign w_next_acc = w_base + tune_word;

  // Stage 1: latch pre-increment phase and mode, advance the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_p    <= '0;
      r_mode <= c_mode_sine;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_p    <= w_base[PHASE_W-1 -: c_p_bits];
        r_mode <= mode;
        r_acc  <= w_next_acc;
      end else if (phase_reset) begin
        r_acc  <= '0;
      end
    end
  end

  // Sine: fold the second half onto the first, then mirror the quarter table.
  assign w_k      = r_p[c_p_bits-1 -: 8];
  assign w_kf     = (w_k > 8'd128) ? (8'd0 - w_k) : w_k;
  assign w_sine11 = (w_kf < 8'd64) ? quarter_sine(w_kf[6:0])
                                   : 11'd2047 - quarter_sine(7'(8'd128 - w_kf));

  generate
    if (OUT_W > 11) begin : g_scale_up
      assign w_sine = {w_sine11, {(OUT_W-11){1'b0}}};
    end else if (OUT_W < 11) begin : g_scale_down
      assign w_sine = w_sine11[10 -: OUT_W];
    end else begin : g_scale_none
      assign w_sine = w_sine11;
    end
  endgenerate

  assign w_msb   = r_p[c_p_bits-1];
  assign w_tri_x = r_p[c_p_bits-2 -: OUT_W];

  always_comb begin
    w_wave = '0;
    case (r_mode)
      c_mode_sine:   w_wave = w_sine;
      c_mode_tri:    w_wave = w_msb ? ~w_tri_x : w_tri_x;
      c_mode_saw:    w_wave = r_p[c_p_bits-1 -: OUT_W];
      c_mode_square: w_wave = {OUT_W{w_msb}};
      default:       w_wave = '0;
    endcase
  end

  // Stage 2: register the waveform; sample holds between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= r_v1;
      if (r_v1) begin
        sample <= w_wave;
      end
    end
  end

`ifdef WAVE_OSC_SYNC_EN
  logic w_carry;
  logic r_wrap_pend;
  logic r_sync1;

  // The unsigned sum wrapped iff it ended up smaller than the addend.
  assign w_carry = (w_next_acc < tune_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap_pend <= 1'b0;
      r_sync1     <= 1'b0;
      sync_out    <= 1'b0;
    end else begin
      sync_out <= r_v1 & r_sync1;
      if (w_accept) begin
        r_sync1     <= r_wrap_pend | phase_reset;
        r_wrap_pend <= w_carry;
      end else if (phase_reset) begin
        r_wrap_pend <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wave_oscillator.sv
// +----------------------------------------------------------------------------+
// | tb_wave_oscillator: randomized scoreboard bench for wave_oscillator.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wave_oscillator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] tune_word = '0;
  logic [1:0]  mode = '0;
  logic        phase_reset = 1'b0;
  logic [10:0] sample;
  logic        sample_valid;
`ifdef WAVE_OSC_SYNC_EN
  logic        sync_out;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int val;
    int due;
    bit sync;
  } exp_t;
  exp_t exp_q[$];

  int m_acc = 0;
  bit m_wrap = 1'b0;
  int last_sample = 0;

  wave_oscillator #(.PHASE_W(16), .OUT_W(11)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sample_tick (sample_tick),
    .tune_word   (tune_word),
    .mode        (mode),
    .phase_reset (phase_reset),
    .sample      (sample),
`ifdef WAVE_OSC_SYNC_EN
    .sync_out    (sync_out),
`endif
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Quarter-wave value computed straight from the cosine definition.
  function automatic int qtab(input int j);
    real v;
    v = 1023.5 * (1.0 - $cos(3.14159265358979323846 * j / 128.0));
    return int'($floor(v + 0.5 + 1.0e-9));
  endfunction

  function automatic int ref_sample(input int p, input int md);
    int k;
    int x;
    int r;
    bit hi;
    hi = (p >= 32768);
    r = 0;
    case (md)
      0: begin
        k = p / 256;
        if (k > 128) k = 256 - k;
        r = (k < 64) ? qtab(k) : 2047 - qtab(128 - k);
      end
      1: begin
        x = (p / 16) % 2048;
        r = hi ? 2047 - x : x;
      end
      2: r = p / 32;
      default: r = hi ? 2047 : 0;
    endcase
    return r;
  endfunction

  // One clock cycle of stimulus; accepted ticks push their expected sample.
  task automatic drive(input bit e, input bit t, input int tw, input int md, input bit pr);
    int p;
    exp_t x;
    en = e;
    sample_tick = t;
    tune_word = tw[15:0];
    mode = md[1:0];
    phase_reset = pr;
    if (e && t) begin
      p = pr ? 0 : m_acc;
      x.val = ref_sample(p, md);
      x.due = cyc + 2;
      x.sync = m_wrap | pr;
      exp_q.push_back(x);
      m_acc = p + tw;
      m_wrap = (m_acc >= 65536);
      m_acc = m_acc % 65536;
    end else if (pr) begin
      m_acc = 0;
      m_wrap = 1'b1;
    end
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    phase_reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_sample = 0;
    end else if (sample_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: sample %0d with nothing outstanding (cycle %0d)", sample, cyc);
      end else begin
        e = exp_q.pop_front();
        check("sample", int'(sample), e.val);
        check("latency", cyc, e.due);
`ifdef WAVE_OSC_SYNC_EN
        check("sync_out", int'(sync_out), int'(e.sync));
`endif
      end
      last_sample = int'(sample);
    end else begin
      check("hold", int'(sample), last_sample);
`ifdef WAVE_OSC_SYNC_EN
      check("sync_idle", int'(sync_out), 0);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tw;
    int md;
    #12;
    check("reset_sample", int'(sample), 0);
    check("reset_valid", int'(sample_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Sine at quarter steps, back to back
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 16384, 0, 1'b0);
    idle(3);

    // Triangle, then square after a phase reset
    drive(1'b0, 1'b0, 0, 1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16384, 1, 1'b0);
    drive(1'b0, 1'b0, 0, 3, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16384, 3, 1'b0);
    idle(3);

    // Saw through an accumulator wrap
    drive(1'b0, 1'b0, 0, 2, 1'b1);
    for (int i = 0; i < 18; i++) drive(1'b1, 1'b1, 4096, 2, 1'b0);

    // Gated ticks mid-stream must be ignored
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4096, 2, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4096, 2, 1'b0);
    idle(3);

    // phase_reset coincident with a tick
    drive(1'b1, 1'b1, 16384, 0, 1'b1);
    drive(1'b1, 1'b1, 16384, 0, 1'b0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tw = int'($urandom_range(0, 65535));
      md = int'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, tw, md,
            $urandom_range(0, 15) == 0);
    end
    idle(4);

    // Reset in the middle of the pipeline
    drive(1'b1, 1'b1, 16384, 0, 1'b1);
    drive(1'b1, 1'b1, 16384, 0, 1'b0);
    idle(3);
    drive(1'b1, 1'b1, 16384, 0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    m_acc = 0;
    m_wrap = 1'b0;
    #1;
    check("midreset_sample", int'(sample), 0);
    check("midreset_valid", int'(sample_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    // First ticks after reset start from phase 0
    drive(1'b1, 1'b1, 4096, 2, 1'b0);
    drive(1'b1, 1'b1, 4096, 2, 1'b0);
    drive(1'b1, 1'b1, 4096, 1, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wave_oscillator.md
WAVE_OSCILLATOR -- requirements
Module: wave_oscillator

Interface
REQ-001 Parameter PHASE_W, default 16, SHALL set the phase accumulator width; legal when PHASE_W >= OUT_W+1 and PHASE_W >= 10.
REQ-002 Parameter OUT_W, default 11, SHALL set the unsigned sample width; MAX = 2^OUT_W-1.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL gate ticks; when low, ticks SHALL be ignored.
REQ-006 sample_tick  input  1  SHALL request one new sample per high cycle.
REQ-007 tune_word  input  PHASE_W  SHALL be the phase increment per accepted tick.
REQ-008 mode  input  2  SHALL select the waveform: 0 sine, 1 triangle, 2 saw, 3 square.
REQ-009 phase_reset  input  1  SHALL force the accumulator to 0.
REQ-010 sample  output  OUT_W  SHALL be the current unsigned sample.
REQ-011 sample_valid  output  1  SHALL pulse high for one cycle when sample updates.

Function
REQ-012 A tick SHALL be accepted when en=1 and sample_tick=1 in the same cycle.
REQ-013 On acceptance, stage 1 SHALL latch phase p = acc (pre-increment), latch mode, and update acc <= (acc + tune_word) mod 2^PHASE_W.
REQ-014 Stage 2 SHALL compute the waveform from the latched p and mode, register it into sample, and assert sample_valid, giving a fixed latency of 2 cycles from tick to sample_valid.
REQ-015 Back-to-back ticks every cycle SHALL be accepted; the pipeline SHALL produce one sample_valid per accepted tick, in order.
REQ-016 phase_reset=1 SHALL set acc to 0 and take priority over the increment; an accepted tick in the same cycle SHALL use p=0, and acc SHALL be tune_word afterwards.
REQ-017 sample SHALL hold its value between sample_valid pulses; en=0 SHALL NOT flush samples already in flight.
REQ-018 Sine SHALL use k = p[PHASE_W-1 -: 8] and a 65-entry quarter table T[j] = round-half-up(1023.5*(1-cos(pi*j/128))) for j=0..64, scaled to OUT_W by left-justifying when OUT_W != 11.
REQ-019 Sine at OUT_W=11 SHALL be T[k] for k<64, 2047-T[128-k] for 64<=k<=128, and the value for 256-k when k>128 (0 at k=0, 1023 at k=64, 2047 at k=128).
REQ-020 Saw SHALL equal p[PHASE_W-1 -: OUT_W].
REQ-021 Square SHALL equal 0 when p[PHASE_W-1]=0, and MAX otherwise.
REQ-022 Triangle SHALL equal x when p[PHASE_W-1]=0 and ~x otherwise, where x = p[PHASE_W-2 -: OUT_W].
REQ-023 A mode change SHALL take effect on the next accepted tick and SHALL NOT reset acc.
REQ-024 Accumulator overflow SHALL wrap silently with no other side effect unless REQ-029 is compiled in.

Reset
REQ-025 While rst_n=0, acc, sample, sample_valid and every pipeline valid bit SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-pipeline SHALL discard in-flight samples; no sample_valid SHALL follow reset release until a new tick is accepted.
REQ-027 The first tick after reset SHALL produce the sample for p=0.

Configuration
REQ-028 Macro WAVE_OSC_SYNC_EN SHALL control a hard-sync output.
REQ-029 With WAVE_OSC_SYNC_EN defined, output sync_out (1 bit) SHALL pulse together with sample_valid for the first sample whose p results from an accumulator wrap. A phase_reset SHALL count as a wrap for this purpose.
REQ-030 Without WAVE_OSC_SYNC_EN, the sync_out port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Sine: defaults, mode=0, tune_word=16384, 5 consecutive ticks -> samples 0, 1023, 2047, 1023, 0, each valid exactly 2 cycles after its tick.
REQ-032 Triangle/square: tune_word=16384, 4 ticks with mode=1 -> 0, 1024, 2047, 1023; repeat with mode=3 after phase_reset -> 0, 0, 2047, 2047.
REQ-033 Saw and wrap: mode=2, tune_word=4096, 18 ticks -> 0, 128, ..., 1920, 0, 128; with WAVE_OSC_SYNC_EN, sync_out high only on the 17th sample.
REQ-034 Gating: en=0 for 3 ticks mid-stream -> no sample_valid, sample held, and the next accepted tick continues from the unchanged acc.
REQ-035 Priority: phase_reset and a tick in the same cycle with tune_word=16384 -> that sample = 0; next sample (sine) = 1023.
REQ-036 Reset: assert rst_n=0 one cycle after a tick -> sample=0 and sample_valid=0 immediately, and no valid pulse after release.
